mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the processor's Read/Write memory interface. The
//  datapath drives Read or Write, the address (MAR[8:0]) and the write data (MDR).
//  This block services the request after a configurable number of wait states.
//  It returns read data, then signals completion with a four-phase done handshake
//  that the control unit waits on. It replaces the fixed-latency RAM on the datapath.
// PARAMETERS
//  ADDR_W       9    address width; the array holds 2**ADDR_W 32-bit words
//  WAIT_STATES  2    extra cycles before the array access (0..15)
// PORTS
//  clk     in   1       rising-edge clock
//  clr     in   1       asynchronous, active-low reset
//  Read    in   1       read request; level, held until done is seen
//  Write   in   1       write request; level, held until done is seen
//  addr    in   ADDR_W  word address; sampled when the request is accepted
//  wdata   in   32      write data; sampled when the request is accepted
//  rdata   out  32      read data; valid while done=1, held until the next read completes
//  done    out  1       request complete; high for exactly one cycle
//  busy    out  1       high from the accept cycle until the return to IDLE
//  err     out  1       pulses together with done when Read and Write were both high at accept
// BEHAVIOUR
//  Reset (clr=0, asynchronous):
//   - state=IDLE, rdata=0, done=0, busy=0, err=0, wait counter=0.
//   - Array contents are NOT cleared.
//   - A reset mid-request aborts it with no array write.
//  FSM states: IDLE, WAIT, ACCESS, DONE, HOLD.
//   - IDLE: on (Read|Write)=1, latch addr, wdata and op; set busy=1; cnt=WAIT_STATES.
//     If WAIT_STATES=0 -> ACCESS, else -> WAIT.
//   - WAIT: cnt decrements each cycle; at cnt==1 -> ACCESS.
//   - ACCESS: read latches mem[addr] into rdata, or write stores wdata to mem[addr].
//     With an error op there is no access and rdata is unchanged. -> DONE.
//   - DONE: done=1 (and err=1 for an error op) for this cycle only. -> HOLD.
//   - HOLD: wait until Read=0 and Write=0, then -> IDLE with busy=0.
//     A new request is accepted at the earliest on the cycle after IDLE is re-entered.
//  Latency: request accepted at edge 0; done is high in cycle WAIT_STATES+2.
//  addr and wdata changes after accept are ignored; the latched copies are used.
//  Dropping Read/Write before done does not cancel the request; it completes normally.
//  Address range is 0..2**ADDR_W-1; there are no out-of-range cases and no wrap logic.
//  The array is a synchronous register/RAM array. A read in ACCESS returns the
//  value from the most recent completed write to that address.
// TESTING
//  - Reset: clr=0 mid-WAIT of a write to addr 5 -> all outputs 0, state IDLE,
//    mem[5] unchanged.
//  - Write then read: Write, addr=9'h010, wdata=32'hDEAD_BEEF, WAIT_STATES=2.
//    -> done at cycle 4, err=0. Then Read addr=9'h010 -> rdata=32'hDEAD_BEEF with done.
//  - Zero wait: WAIT_STATES=0; Read addr=0 after writing 32'h1234 ->
//    done in cycle 2, rdata=32'h1234.
//  - Four-phase hold: keep Read high 5 cycles after done -> done pulses once,
//    busy stays 1, no second access; busy drops the cycle after Read=0.
//  - Conflict: Read=Write=1 at addr 3 holding 32'hA5 -> done=err=1 together,
//    mem[3] still 32'hA5, rdata unchanged.
//  - Address churn: accept a write to addr 7, then change addr/wdata during WAIT ->
//    only mem[7] is updated, with the originally sampled wdata.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder for the processor Read/Write interface.
//            Accepts a level-held request, waits WAIT_STATES cycles, performs
//            one access to a 2**ADDR_W x 32 array, pulses done for one cycle
//            and then waits for the request to be dropped (four-phase
//            handshake) before returning to idle.
// Ports    : clk    - rising-edge clock
//            clr    - asynchronous active-low reset
//            Read   - read request (level)
//            Write  - write request (level)
//            addr   - word address, sampled at accept
//            wdata  - write data, sampled at accept
//            rdata  - read data, held until the next read completes
//            done   - one-cycle completion pulse
//            busy   - high from accept until the return to idle
//            err    - pulses with done when Read and Write were both high
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              busy,
  output logic              err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_DONE   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                op_rd_q, op_rd_d;
  logic                op_wr_q, op_wr_d;
  logic                op_err_q, op_err_d;
  logic                mem_we;

  // Storage array; intentionally has no reset so contents survive clr.
  logic [31:0] mem [2**ADDR_W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    op_rd_d  = op_rd_q;
    op_wr_d  = op_wr_q;
    op_err_d = op_err_q;
    mem_we   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Read || Write) begin
          addr_d   = addr;
          wdata_d  = wdata;
          // A simultaneous Read and Write is an error op: no access at all.
          op_rd_d  = Read & ~Write;
          op_wr_d  = Write & ~Read;
          op_err_d = Read & Write;
          cnt_d    = WAIT_INIT;
          state_d  = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (op_rd_q) begin
          rdata_d = mem[addr_q];
        end
        mem_we  = op_wr_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Second half of the handshake: requester must drop both strobes.
        if (!Read && !Write) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      op_rd_q  <= 1'b0;
      op_wr_q  <= 1'b0;
      op_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      op_rd_q  <= op_rd_d;
      op_wr_q  <= op_wr_d;
      op_err_q <= op_err_d;
    end
  end

  // mem_we derives from state_q, which clr forces to IDLE, so a reset
  // mid-request can never produce a write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign done  = (state_q == S_DONE);
  assign err   = (state_q == S_DONE) & op_err_q;
  assign busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed self-checking bench for mem_responder. Instance u_dut_a
//            uses WAIT_STATES=2, instance u_dut_z uses WAIT_STATES=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic        clk;
  logic        clr;

  logic        rd_a, wr_a;
  logic [8:0]  addr_a;
  logic [31:0] wdata_a, rdata_a;
  logic        done_a, busy_a, err_a;

  logic        rd_z, wr_z;
  logic [8:0]  addr_z;
  logic [31:0] wdata_z, rdata_z;
  logic        done_z, busy_z, err_z;

  int n_checks = 0;
  int n_errors = 0;

  mem_responder #(.ADDR_W(9), .WAIT_STATES(2)) u_dut_a (
    .clk(clk), .clr(clr), .Read(rd_a), .Write(wr_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .done(done_a), .busy(busy_a), .err(err_a)
  );

  mem_responder #(.ADDR_W(9), .WAIT_STATES(0)) u_dut_z (
    .clk(clk), .clr(clr), .Read(rd_z), .Write(wr_z), .addr(addr_z),
    .wdata(wdata_z), .rdata(rdata_z), .done(done_z), .busy(busy_z), .err(err_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_in(input bit z, input logic r, input logic w,
                        input logic [8:0] a, input logic [31:0] d);
    if (z) begin
      rd_z = r; wr_z = w; addr_z = a; wdata_z = d;
    end else begin
      rd_a = r; wr_a = w; addr_a = a; wdata_a = d;
    end
  endtask

  // One full four-phase transaction. Reports cycles-to-done (0 = timeout)
  // and the rdata/err seen in the done cycle. Optionally changes addr/wdata
  // in the first cycle after accept, and holds the request 'hold' extra
  // cycles after done before dropping it.
  task automatic txn(input bit z, input logic r, input logic w,
                     input logic [8:0] a, input logic [31:0] d, input int hold,
                     input bit chg, input logic [8:0] a2, input logic [31:0] d2,
                     output int lat, output logic [31:0] rd, output logic er);
    int dl;
    lat = 0;
    rd  = 32'd0;
    er  = 1'b0;
    set_in(z, r, w, a, d);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (chg && i == 1) set_in(z, r, w, a2, d2);
      if (z ? done_z : done_a) begin
        lat = i;
        rd  = z ? rdata_z : rdata_a;
        er  = z ? err_z : err_a;
        break;
      end
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_done", 32'(z ? done_z : done_a), 32'd0);
      check("hold_busy", 32'(z ? busy_z : busy_a), 32'd1);
    end
    set_in(z, 1'b0, 1'b0, a, d);
    dl = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (!(z ? busy_z : busy_a)) begin
        dl = i;
        break;
      end
    end
    // Dropped in DONE: DONE->HOLD->IDLE takes two edges; dropped in HOLD: one.
    check("busy_drop_lat", 32'(dl), (hold > 0) ? 32'd1 : 32'd2);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;

  initial begin
    clr = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
    set_in(1'b1, 1'b0, 1'b0, 9'd0, 32'd0);
    @(posedge clk); #1;
    check("rst_rdata", rdata_a, 32'd0);
    check("rst_done",  32'(done_a), 32'd0);
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_err",   32'(err_a),  32'd0);
    clr = 1'b1;
    @(posedge clk); #1;

    // Write then read back, WAIT_STATES=2 -> done in cycle 4.
    txn(1'b0, 1'b0, 1'b1, 9'h010, 32'hDEAD_BEEF, 0, 1'b0, 9'd0, 32'd0, lat, rd, er);
    check("wr_lat", 32'(lat), 32'd4);
    check("wr_err", 32'(er), 32'd0);
    txn(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 0, 1'b0, 9'd0, 32'd0, lat, rd, er);
    check("rd_lat",   32'(lat), 32'd4);
    check("rd_data",  rd, 32'hDEAD_BEEF);
    check("rd_err",   32'(er), 32'd0);

    // Preload addresses 3, 8 and 5.
    txn(1'b0, 1'b0, 1'b1, 9'd3, 32'h0000_00A5, 0, 1'b0, 9'd0, 32'd0, lat, rd, er);
    txn(1'b0, 1'b0, 1'b1, 9'd8, 32'h0000_0008, 0, 1'b0, 9'd0, 32'd0, lat, rd, er);
    txn(1'b0, 1'b0, 1'b1, 9'd5, 32'h5555_0005, 0, 1'b0, 9'd0, 32'd0, lat, rd, er);

    // Conflict: both strobes -> err with done, no access, rdata unchanged.
    txn(1'b0, 1'b1, 1'b1, 9'd3, 32'hFFFF_FFFF, 0, 1'b0, 9'd0, 32'd0, lat, rd, er);
    check("cf_lat",   32'(lat), 32'd4);
    check("cf_err",   32'(er), 32'd1);
    check("cf_rdata", rd, 32'hDEAD_BEEF);
    txn(1'b0, 1'b1, 1'b0, 9'd3, 32'h0, 0, 1'b0, 9'd0, 32'd0, lat, rd, er);
    check("cf_mem3",  rd, 32'h0000_00A5);

    // Four-phase hold: Read kept high 5 cycles after done.
    txn(1'b0, 1'b1, 1'b0, 9'd8, 32'h0, 5, 1'b0, 9'd0, 32'd0, lat, rd, er);
    check("hold_lat",  32'(lat), 32'd4);
    check("hold_data", rd, 32'h0000_0008);

    // Address churn during WAIT: only mem[7] gets the originally sampled data.
    txn(1'b0, 1'b0, 1'b1, 9'd7, 32'h7777_0007, 0, 1'b1, 9'd8, 32'h8888_8888, lat, rd, er);
    check("ch_lat", 32'(lat), 32'd4);
    txn(1'b0, 1'b1, 1'b0, 9'd7, 32'h0, 0, 1'b0, 9'd0, 32'd0, lat, rd, er);
    check("ch_mem7", rd, 32'h7777_0007);
    txn(1'b0, 1'b1, 1'b0, 9'd8, 32'h0, 0, 1'b0, 9'd0, 32'd0, lat, rd, er);
    check("ch_mem8", rd, 32'h0000_0008);

    // Reset in the middle of a write to addr 5.
    txn(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 0, 1'b0, 9'd0, 32'd0, lat, rd, er);
    set_in(1'b0, 1'b0, 1'b1, 9'd5, 32'hBAD0_0005);
    @(posedge clk); #1;
    check("mid_busy", 32'(busy_a), 32'd1);
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    check("mr_rdata", rdata_a, 32'd0);
    check("mr_done",  32'(done_a), 32'd0);
    check("mr_busy",  32'(busy_a), 32'd0);
    check("mr_err",   32'(err_a),  32'd0);
    set_in(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
    @(posedge clk); #1;
    check("mr_busy_hold", 32'(busy_a), 32'd0);
    clr = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 1'b1, 1'b0, 9'd5, 32'h0, 0, 1'b0, 9'd0, 32'd0, lat, rd, er);
    check("mr_mem5", rd, 32'h5555_0005);

    // Zero wait states: done in cycle 2.
    txn(1'b1, 1'b0, 1'b1, 9'd0, 32'h0000_1234, 0, 1'b0, 9'd0, 32'd0, lat, rd, er);
    check("z_wr_lat", 32'(lat), 32'd2);
    txn(1'b1, 1'b1, 1'b0, 9'd0, 32'h0, 0, 1'b0, 9'd0, 32'd0, lat, rd, er);
    check("z_rd_lat",  32'(lat), 32'd2);
    check("z_rd_data", rd, 32'h0000_1234);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
